// File: rtl/dispatch_credit_ctrl.sv
// Free-entry credit tracking for the ROB and the ALU/Branch/LSU reservation stations,
// with a programmable post-flush quiet period. Every output decodes registered state only.

module credit_counter #(
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         frozen,
    input  logic                         alloc,
    input  logic                         ret,
    output logic [$clog2(DEPTH+1)-1:0]   free,
    output logic                         err
);
    localparam int W = $clog2(DEPTH + 1);
    localparam logic [W-1:0] FULL_CNT = W'(DEPTH);

    logic underflow;
    logic overflow;

    assign underflow = alloc && !ret && (free == '0);
    assign overflow  = ret && !alloc && (free == FULL_CNT);
    // Bad credit traffic is only meaningful while running; a flush cycle discards everything.
    assign err       = !clear && !frozen && (underflow || overflow);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            free <= FULL_CNT;
        end else if (!frozen && (alloc != ret) && !underflow && !overflow) begin
            free <= alloc ? free - 1'b1 : free + 1'b1;
        end
    end
endmodule

module dispatch_credit_ctrl #(
    parameter int ROB_DEPTH    = 16,
    parameter int ALU_RS_DEPTH = 8,
    parameter int BR_RS_DEPTH  = 4,
    parameter int LSU_RS_DEPTH = 8,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                rob_alloc,
    input  logic                                alu_rs_alloc,
    input  logic                                branch_rs_alloc,
    input  logic                                lsu_rs_alloc,
    input  logic                                rob_retire,
    input  logic                                alu_issue,
    input  logic                                branch_issue,
    input  logic                                lsu_issue,
    input  logic                                flush,
    output logic                                rob_full,
    output logic                                alu_rs_full,
    output logic                                branch_rs_full,
    output logic                                lsu_rs_full,
    output logic [$clog2(ROB_DEPTH+1)-1:0]      rob_free,
    output logic [$clog2(ALU_RS_DEPTH+1)-1:0]   alu_rs_free,
    output logic [$clog2(BR_RS_DEPTH+1)-1:0]    branch_rs_free,
    output logic [$clog2(LSU_RS_DEPTH+1)-1:0]   lsu_rs_free,
    output logic                                busy_flush,
    output logic                                credit_err
);
    localparam int QW = $clog2(FLUSH_CYCLES + 1);
    localparam logic [0:0] S_RUN   = 1'b0;
    localparam logic [0:0] S_FLUSH = 1'b1;

    logic [0:0]    state;
    logic [QW-1:0] qcnt;
    logic          frozen;
    logic          rob_err;
    logic          alu_err;
    logic          br_err;
    logic          lsu_err;
    logic          flush_alloc_err;

    assign frozen = (state == S_FLUSH);

    credit_counter #(.DEPTH(ROB_DEPTH)) u_rob (
        .clk(clk), .reset(reset), .clear(flush), .frozen(frozen),
        .alloc(rob_alloc), .ret(rob_retire), .free(rob_free), .err(rob_err)
    );

    credit_counter #(.DEPTH(ALU_RS_DEPTH)) u_alu (
        .clk(clk), .reset(reset), .clear(flush), .frozen(frozen),
        .alloc(alu_rs_alloc), .ret(alu_issue), .free(alu_rs_free), .err(alu_err)
    );

    credit_counter #(.DEPTH(BR_RS_DEPTH)) u_br (
        .clk(clk), .reset(reset), .clear(flush), .frozen(frozen),
        .alloc(branch_rs_alloc), .ret(branch_issue), .free(branch_rs_free), .err(br_err)
    );

    credit_counter #(.DEPTH(LSU_RS_DEPTH)) u_lsu (
        .clk(clk), .reset(reset), .clear(flush), .frozen(frozen),
        .alloc(lsu_rs_alloc), .ret(lsu_issue), .free(lsu_rs_free), .err(lsu_err)
    );

    // Dispatch must stay quiet during the flush window; any alloc there is a protocol error.
    assign flush_alloc_err = frozen && !flush &&
                             (rob_alloc || alu_rs_alloc || branch_rs_alloc || lsu_rs_alloc);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_RUN;
            qcnt       <= '0;
            credit_err <= 1'b0;
        end else begin
            if (flush) begin
                state <= S_FLUSH;
                qcnt  <= QW'(FLUSH_CYCLES);
            end else if (state == S_FLUSH) begin
                qcnt <= qcnt - 1'b1;
                if (qcnt == QW'(1)) begin
                    state <= S_RUN;
                end
            end
            if (rob_err || alu_err || br_err || lsu_err || flush_alloc_err) begin
                credit_err <= 1'b1;
            end
        end
    end

    assign busy_flush     = frozen;
    assign rob_full       = (rob_free == '0) || frozen;
    assign alu_rs_full    = (alu_rs_free == '0) || frozen;
    assign branch_rs_full = (branch_rs_free == '0) || frozen;
    assign lsu_rs_full    = (lsu_rs_free == '0) || frozen;
endmodule
